// File: rtl/slice_stream_reader_if.sv
// Buffer read port (Avalon-MM, 1-cycle latency) and output packet stream (Avalon-ST)
// of the slice stream reader, bundled so the reader sees them as one bus.
interface slice_stream_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;

  modport master (
    output mem_address, mem_chipselect, out_data, out_valid, out_sop, out_eop,
    input  mem_readdata, out_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, out_data, out_valid, out_sop, out_eop,
    output mem_readdata, out_ready
  );
endinterface

// File: rtl/slice_stream_reader.sv
// Reads one slice of the voxel slice buffer per slice pulse and streams it as a packet,
// with a 2-entry skid FIFO credit-matched to the single outstanding buffer read.
module slice_stream_reader #(
  parameter int SLICE_WORDS_LOG2 = 6,
  parameter int NUM_SLICES_LOG2  = 4,
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = SLICE_WORDS_LOG2 + NUM_SLICES_LOG2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       index_pulse,
  input  logic                       slice_pulse,
  input  logic                       clear_overrun,
  slice_stream_reader_if.master      bus,
  output logic [NUM_SLICES_LOG2-1:0] slice_num,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam int ENTRY_W = DATA_W + 2;
  localparam logic [SLICE_WORDS_LOG2-1:0] LAST_WORD = '1;

  state_t                      state_q, state_d;
  logic [NUM_SLICES_LOG2-1:0]  slice_num_q, slice_num_d;
  logic [NUM_SLICES_LOG2-1:0]  next_slice_q, next_slice_d;
  logic [SLICE_WORDS_LOG2-1:0] word_cnt_q, word_cnt_d;
  logic                        inflight_q, inflight_d;
  logic                        inflight_sop_q, inflight_sop_d;
  logic                        inflight_eop_q, inflight_eop_d;
  logic [ENTRY_W-1:0]          fifo_q [2];
  logic [ENTRY_W-1:0]          fifo_d [2];
  logic                        rd_ptr_q, rd_ptr_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic [1:0]                  count_q, count_d;
  logic                        overrun_q, overrun_d;

  logic [ENTRY_W-1:0] head;
  logic [1:0]         occupancy;
  logic               out_valid;
  logic               pop;
  logic               issue;
  logic               start_index;
  logic               start_slice;
  logic               busy_pulse;

  assign head        = fifo_q[rd_ptr_q];
  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid && bus.out_ready;
  // Words held plus the one possibly in flight must never exceed the two FIFO slots.
  assign occupancy   = count_q + {1'b0, inflight_q};
  assign issue       = (state_q == READ) &&
                       ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
  assign start_index = enable && index_pulse;
  assign start_slice = enable && slice_pulse && !index_pulse;
  assign busy_pulse  = (state_q != IDLE) && enable && (index_pulse || slice_pulse);

  always_comb begin
    state_d        = state_q;
    slice_num_d    = slice_num_q;
    next_slice_d   = next_slice_q;
    word_cnt_d     = word_cnt_q;
    fifo_d         = fifo_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    inflight_d     = issue;
    inflight_sop_d = issue && (word_cnt_q == '0);
    inflight_eop_d = issue && (word_cnt_q == LAST_WORD);

    unique case (state_q)
      IDLE: begin
        if (start_index) begin
          slice_num_d  = '0;
          next_slice_d = {{(NUM_SLICES_LOG2-1){1'b0}}, 1'b1};
          word_cnt_d   = '0;
          state_d      = READ;
        end else if (start_slice) begin
          slice_num_d  = next_slice_q;
          next_slice_d = next_slice_q + 1'b1;
          word_cnt_d   = '0;
          state_d      = READ;
        end
      end
      READ: begin
        if (issue) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head[DATA_W+1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A revolution marker during a transfer still re-aligns the slice sequence.
    if (busy_pulse && index_pulse) begin
      next_slice_d = '0;
    end
    overrun_d = (overrun_q && !clear_overrun) || busy_pulse;

    if (inflight_q) begin
      fifo_d[wr_ptr_q] = {inflight_eop_q, inflight_sop_q, bus.mem_readdata};
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      slice_num_q    <= '0;
      next_slice_q   <= '0;
      word_cnt_q     <= '0;
      inflight_q     <= 1'b0;
      inflight_sop_q <= 1'b0;
      inflight_eop_q <= 1'b0;
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      slice_num_q    <= slice_num_d;
      next_slice_q   <= next_slice_d;
      word_cnt_q     <= word_cnt_d;
      inflight_q     <= inflight_d;
      inflight_sop_q <= inflight_sop_d;
      inflight_eop_q <= inflight_eop_d;
      fifo_q[0]      <= fifo_d[0];
      fifo_q[1]      <= fifo_d[1];
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.mem_address    = {slice_num_q, word_cnt_q};
  assign bus.mem_chipselect = issue;
  assign bus.out_valid      = out_valid;
  assign bus.out_data       = head[DATA_W-1:0];
  assign bus.out_sop        = out_valid && head[DATA_W];
  assign bus.out_eop        = out_valid && head[DATA_W+1];
  assign slice_num          = slice_num_q;
  assign busy               = (state_q != IDLE);
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_slice_stream_reader.sv
// Directed bench for slice_stream_reader: expected reads and stream words are queued when
// a transfer is started and retired by a negedge monitor as the DUT presents them.
module tb_slice_stream_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  slice;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       index_pulse;
  logic       slice_pulse;
  logic       clear_overrun;
  logic [3:0] slice_num;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int words_popped = 0;
  int occ = 0;

  exp_t       exp_q[$];
  logic [9:0] addr_q[$];

  logic        hold_valid = 1'b0;
  logic [31:0] hold_data;
  logic        hold_sop;
  logic        hold_eop;

  slice_stream_reader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  slice_stream_reader #(
    .SLICE_WORDS_LOG2(6),
    .NUM_SLICES_LOG2 (4),
    .DATA_W          (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .index_pulse  (index_pulse),
    .slice_pulse  (slice_pulse),
    .clear_overrun(clear_overrun),
    .bus          (bus),
    .slice_num    (slice_num),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {6'h2B, a, 6'h15, ~a};
  endfunction

  // Slice buffer model with fixed one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      bus.mem_readdata <= mem_word(bus.mem_address);
    end
  end

  function automatic logic [63:0] outs_vec();
    return 64'({bus.mem_address, bus.mem_chipselect, bus.out_data, bus.out_valid,
                bus.out_sop, bus.out_eop, slice_num, busy, overrun});
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic idx, input logic sl);
    index_pulse = idx;
    slice_pulse = sl;
    tick();
    index_pulse = 1'b0;
    slice_pulse = 1'b0;
  endtask

  task automatic expect_slice(input logic [3:0] s);
    exp_t       e;
    logic [9:0] a;
    for (int k = 0; k < 64; k++) begin
      a = {s, 6'(k)};
      addr_q.push_back(a);
      e.data  = mem_word(a);
      e.sop   = (k == 0);
      e.eop   = (k == 63);
      e.slice = s;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input logic [3:0] pat);
    int n = 0;
    while (busy && n < 1000) begin
      bus.out_ready = pat[n[1:0]];
      tick();
      n++;
    end
    bus.out_ready = 1'b1;
    check_output("idle_reached", 64'(busy), 64'(0));
    check_output("stream_drained", 64'(exp_q.size()), 64'(0));
    check_output("reads_drained", 64'(addr_q.size()), 64'(0));
  endtask

  task automatic run_slice(input logic idx, input logic sl, input logic [3:0] s);
    expect_slice(s);
    apply_stimulus(idx, sl);
    wait_idle(4'b1111);
    check_output("slice_num", 64'(slice_num), 64'(s));
  endtask

  // Scoreboard monitor: retires reads and stream words, checks stall hold and credit limit.
  always @(negedge clk) begin
    exp_t got;
    logic p;
    if (!reset_n) begin
      occ        = 0;
      hold_valid = 1'b0;
    end else begin
      p = bus.out_valid && bus.out_ready;
      if (bus.mem_chipselect) begin
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_read: got=%0h expected=no read", bus.mem_address);
        end else begin
          check_output("read_address", 64'(bus.mem_address), 64'(addr_q.pop_front()));
        end
      end
      if (p) begin
        got.data  = bus.out_data;
        got.sop   = bus.out_sop;
        got.eop   = bus.out_eop;
        got.slice = slice_num;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got=%0h expected=no word", got);
        end else begin
          check_output("stream_word", 64'(got), 64'(exp_q.pop_front()));
        end
        words_popped++;
      end
      if (hold_valid) begin
        check_output("stall_hold", 64'({bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop}),
                     64'({1'b1, hold_data, hold_sop, hold_eop}));
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_data  = bus.out_data;
      hold_sop   = bus.out_sop;
      hold_eop   = bus.out_eop;
      occ = occ + (bus.mem_chipselect ? 1 : 0) - (p ? 1 : 0);
      if (bus.mem_chipselect || p) begin
        check_output("fifo_credit_le2", 64'(occ > 2), 64'(0));
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gaps;
    int base;
    int n;
    reset_n       = 1'b0;
    enable        = 1'b0;
    index_pulse   = 1'b0;
    slice_pulse   = 1'b0;
    clear_overrun = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs", outs_vec(), 64'(0));
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();

    // First slice after reset: latency, throughput and tags.
    expect_slice(4'd0);
    apply_stimulus(1'b1, 1'b0);
    check_output("busy_after_pulse", 64'(busy), 64'(1));
    check_output("cs_after_pulse", 64'(bus.mem_chipselect), 64'(1));
    tick();
    check_output("valid_low_e1", 64'(bus.out_valid), 64'(0));
    tick();
    check_output("valid_high_e2", 64'(bus.out_valid), 64'(1));
    gaps = 0;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (!bus.out_valid) gaps++;
    end
    check_output("valid_gaps", 64'(gaps), 64'(0));
    tick();
    check_output("busy_after_eop", 64'(busy), 64'(0));
    check_output("first_slice_num", 64'(slice_num), 64'(0));
    check_output("first_sb_empty", 64'(exp_q.size()), 64'(0));

    // Walk the remaining slices and wrap back to slice 0.
    for (int s = 1; s < 16; s++) begin
      run_slice(1'b0, 1'b1, 4'(s));
    end
    run_slice(1'b0, 1'b1, 4'd0);

    // Backpressure pattern 1,0,0,1.
    expect_slice(4'd1);
    apply_stimulus(1'b0, 1'b1);
    wait_idle(4'b1001);
    check_output("stall_slice_num", 64'(slice_num), 64'(1));

    // slice_pulse mid-transfer.
    expect_slice(4'd2);
    apply_stimulus(1'b0, 1'b1);
    repeat (10) tick();
    apply_stimulus(1'b0, 1'b1);
    check_output("overrun_set", 64'(overrun), 64'(1));
    check_output("busy_during_overrun", 64'(busy), 64'(1));
    wait_idle(4'b1111);
    check_output("overrun_sticky", 64'(overrun), 64'(1));
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check_output("overrun_cleared", 64'(overrun), 64'(0));

    // index_pulse mid-transfer realigns the next slice to 0.
    expect_slice(4'd3);
    apply_stimulus(1'b0, 1'b1);
    repeat (10) tick();
    apply_stimulus(1'b1, 1'b0);
    check_output("overrun_index", 64'(overrun), 64'(1));
    wait_idle(4'b1111);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    expect_slice(4'd0);
    apply_stimulus(1'b0, 1'b1);
    repeat (5) tick();
    apply_stimulus(1'b0, 1'b1);
    clear_overrun = 1'b1;
    apply_stimulus(1'b0, 1'b1);
    clear_overrun = 1'b0;
    check_output("clear_vs_set", 64'(overrun), 64'(1));
    wait_idle(4'b1111);
    check_output("realigned_slice", 64'(slice_num), 64'(0));
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;

    // Simultaneous pulses act as index; disabled pulses are ignored.
    expect_slice(4'd0);
    apply_stimulus(1'b1, 1'b1);
    wait_idle(4'b1111);
    check_output("both_pulses_slice", 64'(slice_num), 64'(0));
    enable = 1'b0;
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    repeat (3) tick();
    check_output("disabled_idle", 64'(busy), 64'(0));
    check_output("disabled_overrun", 64'(overrun), 64'(0));
    enable = 1'b1;
    expect_slice(4'd1);
    apply_stimulus(1'b0, 1'b1);
    repeat (8) tick();
    enable = 1'b0;
    apply_stimulus(1'b0, 1'b1);
    check_output("disable_mid_busy", 64'(busy), 64'(1));
    check_output("disable_mid_overrun", 64'(overrun), 64'(0));
    wait_idle(4'b1111);
    check_output("disable_mid_slice", 64'(slice_num), 64'(1));
    enable = 1'b1;

    // Asynchronous reset at word 30, then a clean packet.
    expect_slice(4'd0);
    apply_stimulus(1'b1, 1'b0);
    base = words_popped;
    n = 0;
    while (words_popped < base + 30 && n < 200) begin
      tick();
      n++;
    end
    check_output("reached_word30", 64'(words_popped >= base + 30), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset_outputs", outs_vec(), 64'(0));
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check_output("post_reset_idle", outs_vec(), 64'(0));
    run_slice(1'b1, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slice_stream_reader.md
Name: slice_stream_reader

Overview:
- Downstream consumer of the 1024x32 on-chip slice buffer in the voxel display path.
- On each rotation-synchronous slice pulse, it reads one slice (a contiguous block of words) from the buffer over a read-only Avalon-MM master with fixed 1-cycle read latency.
- It emits the slice as an Avalon-ST packet toward the LED driver serializer.
- A small credit-controlled skid FIFO absorbs output backpressure without losing in-flight reads.

Parameters:
- SLICE_WORDS_LOG2, 6, log2 of words per slice (64 words).
- NUM_SLICES_LOG2, 4, log2 of slices per revolution (16 slices). ADDR_W = SLICE_WORDS_LOG2 + NUM_SLICES_LOG2 (default 10).
- DATA_W, 32, buffer word width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, new pulses are ignored; a slice in progress completes.
- index_pulse  in  1  once-per-revolution marker, single-cycle.
- slice_pulse  in  1  start-next-slice strobe, single-cycle.
- mem_address  out  ADDR_W  buffer word address.
- mem_chipselect  out  1  read strobe; data returns the following cycle.
- mem_readdata  in  DATA_W  buffer read data, valid the cycle after mem_chipselect.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from serializer.
- out_sop  out  1  first word of slice.
- out_eop  out  1  last word of slice.
- slice_num  out  NUM_SLICES_LOG2  index of the slice currently or last streamed.
- busy  out  1  slice transfer in progress.
- overrun  out  1  sticky: a pulse arrived while busy.
- clear_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values: all outputs 0; next_slice=0; FIFO empty; inflight=0; state IDLE.
- State IDLE:
  - index_pulse & enable: slice_num<=0, next_slice<=1, go READ.
  - else slice_pulse & enable: slice_num<=next_slice, next_slice<=next_slice+1 (wraps mod 2^NUM_SLICES_LOG2), go READ.
  - Both pulses in the same cycle are treated as index_pulse alone.
- Pulses while busy:
  - No new transfer starts; overrun<=1.
  - index_pulse while busy still forces next_slice<=0.
  - clear_overrun and a new overrun in the same cycle: overrun stays 1.
- State READ:
  - mem_address = {slice_num, word_cnt}.
  - mem_chipselect high in each cycle a read is issued; word_cnt increments per issue.
  - Issue rule: issue when FIFO count + inflight < 2, or == 2 with a pop (out_valid & out_ready) in the same cycle.
  - After issuing word 2^SLICE_WORDS_LOG2-1, go DRAIN.
- State DRAIN: mem_chipselect=0; return to IDLE the cycle after the eop word is popped.
- busy: high in READ and DRAIN.
- Read return:
  - inflight is a 1-bit register set on issue.
  - mem_readdata is pushed into the 2-entry FIFO on the cycle after issue.
  - The FIFO never overflows by construction; an overflow is an assertion failure in the bench.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - out_sop tags word 0 and out_eop tags the last word; the tags travel with the data in the FIFO.
  - Data and tags hold stable while out_valid & !out_ready.
- Latency: a pulse sampled at edge E0 puts the first read on the bus in the cycle after E0; out_valid rises after E2.
- Throughput: with out_ready held high, one word per cycle; a 64-word slice occupies 64 consecutive valid cycles.
- enable deasserted mid-slice: the current slice completes normally.
- Asynchronous reset mid-slice: immediate return to reset values; the partial packet is dropped with no eop.

Test Plan:
- Reset, then index_pulse with out_ready=1 -> addresses 0..63 on consecutive cycles, first out_valid 2 cycles after pulse, 64 words matching buffer contents, sop on word 0, eop on word 63, slice_num=0, busy low after eop.
- Three slice_pulses after an index_pulse, each once idle -> slice_num 1,2,3; address bases 64,128,192; after 16 slices next_slice wraps to 0.
- out_ready toggled 1,0,0,1 pattern during a slice -> no word lost or duplicated, data stable while stalled, inflight+count never exceeds 2, mem_chipselect drops while FIFO full.
- slice_pulse mid-transfer -> overrun=1, no restart, current packet intact; clear_overrun -> overrun=0; index_pulse mid-transfer -> next pulse reads slice 0.
- index_pulse and slice_pulse in the same cycle -> slice 0 read; enable=0 with a pulse -> no read, overrun unchanged.
- reset_n asserted at word 30 -> all outputs 0 within the same cycle; after release, index_pulse -> clean 64-word packet from address 0.
